// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter with bounded burst lock in front of one RAM port
//
// Purpose:
//   Shares a single port of the on-chip weight/activation RAM among NUM_REQ
//   requesters (DMA fill, PE-array fetch, debug readback, ...). Grants are
//   issued combinationally, one per cycle, round-robin from rr_ptr_q. A
//   requester asserting req_lock keeps the grant for up to MAX_BURST
//   consecutive beats. Read data returns one cycle after acceptance and is
//   flagged to the issuing requester through rsp_valid.
//
// Ports:
//   clk        in   clock, also clocks the RAM port
//   rst        in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]             request valid per requester
//   req_we     in   [NUM_REQ]             1 = write, 0 = read
//   req_lock   in   [NUM_REQ]             keep the grant next cycle
//   req_addr   in   [NUM_REQ*ADDR_WIDTH]  packed addresses, slice i = requester i
//   req_wdata  in   [NUM_REQ*DATA_WIDTH]  packed write data, slice i = requester i
//   req_ready  out  [NUM_REQ]             one-hot grant (accept when valid & ready)
//   rsp_valid  out  [NUM_REQ]             one-hot read-data-valid
//   rsp_rdata  out  [DATA_WIDTH]          read data, shared by all requesters
//   ram_en     out                        RAM port enable
//   ram_we     out                        RAM port write enable
//   ram_addr   out  [ADDR_WIDTH]          RAM port address
//   ram_din    out  [DATA_WIDTH]          RAM port write data
//   ram_dout   in   [DATA_WIDTH]          RAM port read data, 1 cycle after en

module ram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [DATA_WIDTH-1:0]         ram_dout
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] BURST_MAX = BEAT_W'(MAX_BURST);

  // Arbitration state
  logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]  owner_q,     owner_d;
  logic              owner_vld_q, owner_vld_d;
  logic [BEAT_W-1:0] beat_cnt_q,  beat_cnt_d;

  // Read-return tracking
  logic              rd_pend_q,   rd_pend_d;
  logic [IDX_W-1:0]  rd_idx_q,    rd_idx_d;

  // Grant decode
  logic              lock_mode;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_we;
  logic              grant_lock;
  logic [IDX_W:0]    rr_sum;

  // Lock holds only while the owner still requests and has beats left;
  // once exhausted the owner falls back to plain round-robin, where rr_ptr_q
  // already points past it so other waiters win first.
  always_comb begin
    lock_mode = owner_vld_q && req_valid[owner_q] && (beat_cnt_q < BURST_MAX);
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    if (!rst) begin
      if (lock_mode) begin
        grant_vld = 1'b1;
        grant_idx = owner_q;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          // rr_ptr_q + k stays below 2*NUM_REQ, so one subtraction wraps it.
          rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
          if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
            rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
          end
          if (!grant_vld && req_valid[rr_sum[IDX_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = rr_sum[IDX_W-1:0];
          end
        end
      end
    end
  end

  // Steer the granted requester's fields onto the RAM port.
  always_comb begin
    req_ready  = '0;
    grant_we   = 1'b0;
    grant_lock = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && (grant_idx == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        grant_we     = req_we[i];
        grant_lock   = req_lock[i];
        ram_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_din      = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ram_en = grant_vld;
    ram_we = grant_vld && grant_we;
  end

  // Next-state: idle cycles and unlocked grants clear the lock; only an
  // accepted read leaves a response pending for the next cycle.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    beat_cnt_d  = '0;
    rd_pend_d   = 1'b0;
    rd_idx_d    = rd_idx_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
      if (grant_lock) begin
        owner_d     = grant_idx;
        owner_vld_d = 1'b1;
        // Continue counting only inside a live burst; a regrant after the
        // burst limit (lone locker) starts a fresh burst at 1.
        if (lock_mode && (grant_idx == owner_q)) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end else begin
          beat_cnt_d = BEAT_W'(1);
        end
      end
      if (!grant_we) begin
        rd_pend_d = 1'b1;
        rd_idx_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      beat_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  // The RAM registers its output, so read data lines up with rd_pend_q and
  // passes straight through; rst masks a response still in flight.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = !rst && rd_pend_q && (rd_idx_q == IDX_W'(i));
    end
  end

  assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_we;
  logic [NR-1:0]    req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             ram_en;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_din;
  logic [DW-1:0]    ram_dout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioral single-port RAM with registered read output.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst       = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(16'h10 + i);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || ram_en !== 1'b0 || ram_we !== 1'b0 || rsp_valid !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs c=%0d: ready=%b en=%b we=%b rsp=%b, required 0000/0/0/0000",
                 c, req_ready, ram_en, ram_we, rsp_valid);
      end
      next_cycle();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || ram_en !== 1'b1 || ram_addr !== 10'h010) begin
      errors++;
      $display("FAIL reset_first_grant: ready=%b en=%b addr=%h, required 0001/1/010",
               req_ready, ram_en, ram_addr);
    end
    next_cycle();
    clear_reqs();
    #1;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'h110) begin
      errors++;
      $display("FAIL reset_first_rsp: rsp=%b data=%h, required 0001/00000110", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_round_robin();
    int cnt [NR];
    int exp_g, prev_g;
    logic [AW-1:0] prev_a;
    do_reset();
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    prev_g = -1;
    prev_a = '0;
    for (int c = 0; c < 12; c++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(i*16 + cnt[i]);
      #1;
      exp_g = c % NR;
      checks++;
      if (req_ready !== (4'b0001 << exp_g) || ram_addr !== AW'(exp_g*16 + cnt[exp_g]) || ram_we !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant c=%0d: ready=%b addr=%h we=%b, required %b/%h/0",
                 c, req_ready, ram_addr, ram_we, 4'b0001 << exp_g, AW'(exp_g*16 + cnt[exp_g]));
      end
      if (prev_g >= 0) begin
        checks++;
        if (rsp_valid !== (4'b0001 << prev_g) || rsp_rdata !== (32'h100 + 32'(prev_a))) begin
          errors++;
          $display("FAIL rr_rsp c=%0d: rsp=%b data=%h, required %b/%h",
                   c, rsp_valid, rsp_rdata, 4'b0001 << prev_g, 32'h100 + 32'(prev_a));
        end
      end
      prev_g = exp_g;
      prev_a = AW'(exp_g*16 + cnt[exp_g]);
      cnt[exp_g]++;
      next_cycle();
    end
    clear_reqs();
    #1;
    checks++;
    if (rsp_valid !== (4'b0001 << prev_g) || rsp_rdata !== (32'h100 + 32'(prev_a)) || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL rr_last_rsp: rsp=%b data=%h en=%b, required %b/%h/0",
               rsp_valid, rsp_rdata, ram_en, 4'b0001 << prev_g, 32'h100 + 32'(prev_a));
    end
  endtask

  task automatic test_write_then_read();
    do_reset();
    req_valid = 4'b0010;
    req_we    = 4'b0010;
    req_addr[1*AW +: AW]  = 10'h03A;
    req_wdata[1*DW +: DW] = 32'hDEADBEEF;
    #1;
    checks++;
    if (req_ready !== 4'b0010 || ram_we !== 1'b1 || ram_addr !== 10'h03A || ram_din !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_issue: ready=%b we=%b addr=%h din=%h, required 0010/1/03a/deadbeef",
               req_ready, ram_we, ram_addr, ram_din);
    end
    next_cycle();
    clear_reqs();
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 10'h03A;
    #1;
    checks++;
    if (req_ready !== 4'b0100 || ram_we !== 1'b0 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL rd_issue: ready=%b we=%b rsp=%b, required 0100/0/0000", req_ready, ram_we, rsp_valid);
    end
    next_cycle();
    clear_reqs();
    #1;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'hDEADBEEF || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_data: rsp=%b data=%h en=%b, required 0100/deadbeef/0", rsp_valid, rsp_rdata, ram_en);
    end
  endtask

  task automatic test_burst_limit();
    int rem0, rem3, exp_g, prev_g;
    logic [AW-1:0] cur_a, prev_a;
    do_reset();
    rem0   = 12;
    rem3   = 1;
    prev_g = -1;
    prev_a = '0;
    for (int c = 0; c < 13; c++) begin
      clear_reqs();
      req_valid[0] = (rem0 > 0);
      req_lock[0]  = 1'b1;
      req_addr[0*AW +: AW] = AW'(12'h040 + (12 - rem0));
      req_valid[3] = (rem3 > 0);
      req_addr[3*AW +: AW] = 10'h070;
      #1;
      exp_g = (c == 8) ? 3 : 0;
      cur_a = (exp_g == 3) ? 10'h070 : AW'(12'h040 + (12 - rem0));
      checks++;
      if (req_ready !== (4'b0001 << exp_g) || ram_addr !== cur_a) begin
        errors++;
        $display("FAIL burst_grant c=%0d: ready=%b addr=%h, required %b/%h",
                 c, req_ready, ram_addr, 4'b0001 << exp_g, cur_a);
      end
      if (prev_g >= 0) begin
        checks++;
        if (rsp_valid !== (4'b0001 << prev_g) || rsp_rdata !== (32'h100 + 32'(prev_a))) begin
          errors++;
          $display("FAIL burst_rsp c=%0d: rsp=%b data=%h, required %b/%h",
                   c, rsp_valid, rsp_rdata, 4'b0001 << prev_g, 32'h100 + 32'(prev_a));
        end
      end
      if (req_ready[0]) rem0--;
      if (req_ready[3]) rem3--;
      prev_g = exp_g;
      prev_a = cur_a;
      next_cycle();
    end
    clear_reqs();
    #1;
    checks++;
    if (rem0 !== 0 || rem3 !== 0) begin
      errors++;
      $display("FAIL burst_drain: rem0=%0d rem3=%0d, required 0/0", rem0, rem3);
    end
  endtask

  task automatic test_lone_locker();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      clear_reqs();
      req_valid[2] = 1'b1;
      req_lock[2]  = 1'b1;
      req_addr[2*AW +: AW] = AW'(12'h200 + n);
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL lone_grant n=%0d: ready=%b, required 0100", n, req_ready);
      end
      next_cycle();
      checks++;
      if (int'(dut.beat_cnt_q) !== (n % 8) + 1) begin
        errors++;
        $display("FAIL lone_beat n=%0d: beat_cnt=%0d, required %0d", n, int'(dut.beat_cnt_q), (n % 8) + 1);
      end
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req_valid = 4'b0010;
    req_addr[1*AW +: AW] = 10'h005;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_accept: ready=%b, required 0010", req_ready);
    end
    next_cycle();
    clear_reqs();
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_rsp_n1: rsp=%b, required 0000", rsp_valid);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 4'b0000 || int'(dut.rr_ptr_q) !== 0) begin
      errors++;
      $display("FAIL midrst_rsp_n2: rsp=%b rr_ptr=%0d, required 0000/0", rsp_valid, int'(dut.rr_ptr_q));
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'h100 + 32'(a);
    ram_dout = '0;
    test_reset();
    test_round_robin();
    test_write_then_read();
    test_burst_limit();
    test_lone_locker();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
